// File: rtl/rv32i_writeback_unit.sv
// Register-file write arbiter: ALU results plus buffered load returns, with a load scoreboard.
// Optional WB_LOAD_PRIORITY_EN: a full load buffer stalls the ALU and drains one load.
module rv32i_writeback_unit #(
   parameter int NUM_OF_SETS    = 32,
   parameter int DATA_BUS_WIDTH = 32,
   parameter int FIFO_DEPTH     = 4,
   localparam int AW = $clog2(NUM_OF_SETS),
   localparam int DW = DATA_BUS_WIDTH,
   localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   alu_valid,
   input  logic [AW-1:0]          alu_rd,
   input  logic [DW-1:0]          alu_data,
   output logic                   alu_stall,
   input  logic                   ld_issue,
   input  logic [AW-1:0]          ld_issue_rd,
   input  logic                   ld_ret_valid,
   output logic                   ld_ret_ready,
   input  logic [AW-1:0]          ld_ret_rd,
   input  logic [DW-1:0]          ld_ret_data,
   output logic [NUM_OF_SETS-1:0] busy_mask,
   output logic [CW-1:0]          fifo_count,
   output logic                   wr_enable,
   output logic [AW-1:0]          wr_addr,
   output logic [DW-1:0]          wr_data
);

   localparam int PW = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } wb_entry_t;

   wb_entry_t                mem [FIFO_DEPTH];
   wb_entry_t                sel_entry;
   logic [PW-1:0]            head;
   logic [PW-1:0]            tail;
   logic [CW-1:0]            count;
   logic                     full;
   logic                     push;
   logic                     pop;
   logic                     sel_alu;
   logic                     sel_ld;
   logic                     wr_from_ld;
   logic [NUM_OF_SETS-1:0]   busy_next;

   // Ready is taken before any same-edge pop, so a full buffer refuses a push.
   assign full         = (count == CW'(FIFO_DEPTH));
   assign ld_ret_ready = !full;
   assign push         = ld_ret_valid && !full;
   assign fifo_count   = count;

`ifdef WB_LOAD_PRIORITY_EN
   assign alu_stall = alu_valid && full;
`else
   assign alu_stall = 1'b0;
`endif

   assign sel_alu = alu_valid && !alu_stall;
   assign sel_ld  = !sel_alu && (count != '0);
   assign pop     = sel_ld;

   always_comb begin
      sel_entry = mem[head];
      if (sel_alu) begin
         sel_entry.rd   = alu_rd;
         sel_entry.data = alu_data;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[tail] <= '{rd: ld_ret_rd, data: ld_ret_data};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + PW'(1);
         if (pop)  head <= head + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // x0 writes are consumed like any other but never strobed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_enable  <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         wr_from_ld <= 1'b0;
      end else if (sel_alu || sel_ld) begin
         wr_enable  <= (sel_entry.rd != '0);
         wr_addr    <= sel_entry.rd;
         wr_data    <= sel_entry.data;
         wr_from_ld <= sel_ld;
      end else begin
         wr_enable  <= 1'b0;
         wr_from_ld <= 1'b0;
      end
   end

   // Clear on load commit first so a same-edge re-issue of that register keeps it busy.
   always_comb begin
      busy_next = busy_mask;
      if (wr_enable && wr_from_ld) busy_next[wr_addr] = 1'b0;
      if (ld_issue && (ld_issue_rd != '0)) busy_next[ld_issue_rd] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy_mask <= '0;
      else     busy_mask <= busy_next;
   end

endmodule

// File: tb/tb_rv32i_writeback_unit.sv
// Directed bench for rv32i_writeback_unit; outputs sampled 1 time unit after each rising edge.
module tb_rv32i_writeback_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_stall;
   logic        ld_issue;
   logic [4:0]  ld_issue_rd;
   logic        ld_ret_valid;
   logic        ld_ret_ready;
   logic [4:0]  ld_ret_rd;
   logic [31:0] ld_ret_data;
   logic [31:0] busy_mask;
   logic [2:0]  fifo_count;
   logic        wr_enable;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;

   int tests  = 0;
   int failed = 0;
   int first;

   rv32i_writeback_unit dut (
      .clk          (clk),
      .rst          (rst),
      .alu_valid    (alu_valid),
      .alu_rd       (alu_rd),
      .alu_data     (alu_data),
      .alu_stall    (alu_stall),
      .ld_issue     (ld_issue),
      .ld_issue_rd  (ld_issue_rd),
      .ld_ret_valid (ld_ret_valid),
      .ld_ret_ready (ld_ret_ready),
      .ld_ret_rd    (ld_ret_rd),
      .ld_ret_data  (ld_ret_data),
      .busy_mask    (busy_mask),
      .fifo_count   (fifo_count),
      .wr_enable    (wr_enable),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      ld_issue = 1'b0; ld_issue_rd = '0;
      ld_ret_valid = 1'b0; ld_ret_rd = '0; ld_ret_data = '0;
      tick();
      tick();
      chk("rst_wr_enable", wr_enable, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_busy", busy_mask, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_ready", ld_ret_ready, 1);
      chk("rst_stall", alu_stall, 0);
      rst = 1'b0;
      tick();

      // 1: single ALU write
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      tick();
      chk("t1_wr_enable", wr_enable, 1);
      chk("t1_wr_addr", wr_addr, 5);
      chk("t1_wr_data", wr_data, 32'hDEADBEEF);
      alu_valid = 1'b0;
      tick();
      chk("t1_wr_enable_off", wr_enable, 0);
      chk("t1_addr_hold", wr_addr, 5);

      // 2: load issue, return, commit clears scoreboard
      ld_issue = 1'b1; ld_issue_rd = 5'd7;
      tick();
      ld_issue = 1'b0;
      chk("t2_busy_set", busy_mask, 32'h80);
      tick();
      tick();
      chk("t2_busy_hold", busy_mask, 32'h80);
      ld_ret_valid = 1'b1; ld_ret_rd = 5'd7; ld_ret_data = 32'h1234;
      chk("t2_ready", ld_ret_ready, 1);
      tick();
      ld_ret_valid = 1'b0;
      chk("t2_count1", fifo_count, 1);
      chk("t2_no_write_yet", wr_enable, 0);
      tick();
      chk("t2_wr_enable", wr_enable, 1);
      chk("t2_wr_addr", wr_addr, 7);
      chk("t2_wr_data", wr_data, 32'h1234);
      chk("t2_count0", fifo_count, 0);
      chk("t2_busy_until_commit", busy_mask, 32'h80);
      tick();
      chk("t2_wr_enable_off", wr_enable, 0);
      chk("t2_busy_clear", busy_mask, 0);

      // 3: x0 destinations never strobe
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
      ld_ret_valid = 1'b1; ld_ret_rd = 5'd0; ld_ret_data = 32'hAAAA;
      tick();
      alu_valid = 1'b0; ld_ret_valid = 1'b0;
      chk("t3_alu_x0", wr_enable, 0);
      chk("t3_count1", fifo_count, 1);
      tick();
      chk("t3_ld_x0", wr_enable, 0);
      chk("t3_count0", fifo_count, 0);

      // 4: ALU every cycle against five load returns
      alu_valid = 1'b1; alu_rd = 5'd9; ld_ret_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         alu_data = 32'(i); ld_ret_rd = 5'(10 + i); ld_ret_data = 32'(100 + i);
         chk("t4_ready_open", ld_ret_ready, 1);
         tick();
         chk("t4_alu_wins", {wr_enable, wr_addr}, {1'b1, 5'd9});
         chk("t4_alu_data", wr_data, 32'(i));
      end
      ld_ret_rd = 5'd14; ld_ret_data = 32'd104; alu_data = 32'd50;
      chk("t4_count_full", fifo_count, 4);
      chk("t4_ready_full", ld_ret_ready, 0);
`ifdef WB_LOAD_PRIORITY_EN
      chk("t4_stall", alu_stall, 1);
      tick();
      chk("t4_prio_addr", wr_addr, 10);
      chk("t4_prio_data", wr_data, 100);
      chk("t4_prio_count", fifo_count, 3);
      first = 1;
`else
      chk("t4_no_stall", alu_stall, 0);
      tick();
      tick();
      chk("t4_count_stays", fifo_count, 4);
      chk("t4_alu_still", {wr_enable, wr_addr}, {1'b1, 5'd9});
      first = 0;
`endif
      alu_valid = 1'b0; ld_ret_valid = 1'b0;
      for (int i = first; i < 4; i++) begin
         tick();
         chk("t4_drain_en", wr_enable, 1);
         chk("t4_drain_addr", wr_addr, 64'(10 + i));
         chk("t4_drain_data", wr_data, 64'(100 + i));
      end
      tick();
      chk("t4_drained_en", wr_enable, 0);
      chk("t4_drained_count", fifo_count, 0);

      // 5: same-edge commit and re-issue of x3 keeps it busy
      ld_issue = 1'b1; ld_issue_rd = 5'd3;
      tick();
      ld_issue = 1'b0;
      ld_ret_valid = 1'b1; ld_ret_rd = 5'd3; ld_ret_data = 32'h33;
      tick();
      ld_ret_valid = 1'b0;
      tick();
      chk("t5_commit_pending", {wr_enable, wr_addr}, {1'b1, 5'd3});
      ld_issue = 1'b1; ld_issue_rd = 5'd3;
      tick();
      ld_issue = 1'b0;
      chk("t5_set_wins", busy_mask, 32'h8);

      // 5b: asynchronous reset with two buffered loads
      alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h88;
      ld_ret_valid = 1'b1; ld_ret_rd = 5'd4; ld_ret_data = 32'h44;
      tick();
      ld_ret_rd = 5'd6; ld_ret_data = 32'h66;
      tick();
      chk("t5_two_buffered", fifo_count, 2);
      chk("t5_alu_write", {wr_enable, wr_addr}, {1'b1, 5'd8});
      alu_valid = 1'b0; ld_ret_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_wr_enable", wr_enable, 0);
      chk("t5_rst_wr_addr", wr_addr, 0);
      chk("t5_rst_wr_data", wr_data, 0);
      chk("t5_rst_busy", busy_mask, 0);
      chk("t5_rst_count", fifo_count, 0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5_post_rst_idle", wr_enable, 0);
         chk("t5_post_rst_count", fifo_count, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
